// File: rtl/lsc_uart_pkg.sv
// Shared constants and state encoding for the UART command parser.
package lsc_uart_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam logic [7:0] OPC_CAPTURE   = 8'h01;
   localparam logic [7:0] OPC_REGWR     = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPC,
      ST_LEN,
      ST_PAY,
      ST_CSUM,
      ST_EXEC
   } state_e;

endpackage

// File: rtl/lsc_timeout_cnt.sv
// Loadable down-counter with clear; expire_o flags terminal count while enabled and not reloading.
module lsc_timeout_cnt #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // A reload in the terminal cycle wins over expiry.
   assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/lsc_uart_cmd_parser.sv
// Host command packet parser: SYNC, OPC, LEN, PAYLOAD, CSUM -> capture request or register write.
//
// state | meaning
// IDLE  | hunting for the sync byte
// OPC   | waiting for opcode byte
// LEN   | waiting for payload length byte
// PAY   | collecting payload bytes
// CSUM  | waiting for checksum byte; command decoded here
// EXEC  | one-cycle command pulse; incoming byte treated as in IDLE
module lsc_uart_cmd_parser
   import lsc_uart_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int          MAX_LEN   = 4,
   parameter logic [23:0] TIMEOUT   = 24'd2000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic       o_req,
   output logic [7:0] o_amt,
   output logic       o_reg_we,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_err,
   output logic [7:0] o_err_cnt,
   output logic       o_busy
);

   localparam int         PAY_N     = (MAX_LEN < 2) ? 2 : MAX_LEN;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_e     state_q, state_d;
   logic [7:0] opc_q, opc_d;
   logic [3:0] len_q, len_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] sum_q, sum_d;
   logic [7:0] pay_q [PAY_N];
   logic [7:0] pay_d [PAY_N];
   logic [7:0] amt_q, amt_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       req_q, req_d;
   logic       we_q, we_d;
   logic       err_q, err_d;
   logic       reject;
   logic       tmr_en, tmr_clr, tmr_expire;

   assign tmr_en  = (state_q == ST_OPC) || (state_q == ST_LEN) ||
                    (state_q == ST_PAY) || (state_q == ST_CSUM);
   assign tmr_clr = (state_d == ST_IDLE) || (state_d == ST_EXEC);

   lsc_timeout_cnt #(.W(24)) u_tmr (
      .clk        (clk),
      .rst_n      (resetn),
      .clr_i      (tmr_clr),
      .load_i     (i_rx_valid),
      .en_i       (tmr_en),
      .load_val_i (TIMEOUT - 24'd1),
      .expire_o   (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      len_d     = len_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      pay_d     = pay_q;
      amt_d     = amt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_cnt_d = err_cnt_q;
      req_d     = 1'b0;
      we_d      = 1'b0;
      err_d     = 1'b0;
      reject    = 1'b0;

      case (state_q)
         ST_IDLE, ST_EXEC: begin
            state_d = (i_rx_valid && (i_rx_data == SYNC_BYTE)) ? ST_OPC : ST_IDLE;
         end
         ST_OPC: if (i_rx_valid) begin
            opc_d   = i_rx_data;
            sum_d   = i_rx_data;
            state_d = ST_LEN;
         end
         ST_LEN: if (i_rx_valid) begin
            sum_d = sum_q + i_rx_data;
            if (i_rx_data > MAX_LEN_B) begin
               reject = 1'b1;
            end else begin
               len_d   = i_rx_data[3:0];
               idx_d   = 4'd0;
               state_d = (i_rx_data == 8'd0) ? ST_CSUM : ST_PAY;
            end
         end
         ST_PAY: if (i_rx_valid) begin
            for (int i = 0; i < PAY_N; i++) begin
               if (idx_q == i[3:0]) pay_d[i] = i_rx_data;
            end
            sum_d = sum_q + i_rx_data;
            if (idx_q == len_q - 4'd1) state_d = ST_CSUM;
            else                       idx_d   = idx_q + 4'd1;
         end
         ST_CSUM: if (i_rx_valid) begin
            // Decode at the checksum strobe so the pulse is visible in the EXEC cycle.
            if (i_rx_data != sum_q) begin
               reject = 1'b1;
            end else if ((opc_q == OPC_CAPTURE) && (len_q == 4'd1)) begin
               amt_d   = pay_q[0];
               req_d   = 1'b1;
               state_d = ST_EXEC;
            end else if ((opc_q == OPC_REGWR) && (len_q == 4'd2)) begin
               addr_d  = pay_q[0];
               wdata_d = pay_q[1];
               we_d    = 1'b1;
               state_d = ST_EXEC;
            end else begin
               reject = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (tmr_expire) reject = 1'b1;

      if (reject) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         opc_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         sum_q     <= '0;
         for (int i = 0; i < PAY_N; i++) pay_q[i] <= '0;
         amt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_cnt_q <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         pay_q     <= pay_d;
         amt_q     <= amt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_cnt_q <= err_cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         err_q     <= err_d;
      end
   end

   assign o_req       = req_q;
   assign o_amt       = amt_q;
   assign o_reg_we    = we_q;
   assign o_reg_addr  = addr_q;
   assign o_reg_wdata = wdata_q;
   assign o_err       = err_q;
   assign o_err_cnt   = err_cnt_q;
   assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsc_uart_cmd_parser.sv
// Self-checking bench for lsc_uart_cmd_parser: packet table, corner sequences and random packets.
module tb_lsc_uart_cmd_parser;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       o_req, o_reg_we, o_err, o_busy;
   logic [7:0] o_amt, o_reg_addr, o_reg_wdata, o_err_cnt;

   lsc_uart_cmd_parser #(.TIMEOUT(24'd16)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_req       (o_req),
      .o_amt       (o_amt),
      .o_reg_we    (o_reg_we),
      .o_reg_addr  (o_reg_addr),
      .o_reg_wdata (o_reg_wdata),
      .o_err       (o_err),
      .o_err_cnt   (o_err_cnt),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_req = 0, n_we = 0, n_err = 0;

   always @(negedge clk) begin
      if (resetn) begin
         if (o_req)    n_req++;
         if (o_reg_we) n_we++;
         if (o_err)    n_err++;
      end
   end

   typedef struct packed {
      logic [63:0] bytes;
      int          n;
      int          d_req;
      int          d_we;
      int          d_err;
      logic [7:0]  amt;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  cnt;
   } vec_t;

   vec_t       tbl [10];
   logic [7:0] exp_amt = 8'h00, exp_addr = 8'h00, exp_wdata = 8'h00, exp_cnt = 8'h00;
   int         b_req, b_we, b_err;

   logic [7:0] r_opc, r_len, r_good, r_csum, r_jb;
   logic [7:0] r_pay [4];
   int         e_req, e_we, e_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin @(posedge clk); #1; end
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic snap();
      b_req = n_req; b_we = n_we; b_err = n_err;
   endtask

   task automatic settle(input string tag, input int dreq, input int dwe, input int derr);
      repeat (3) begin @(posedge clk); #1; end
      chk({tag, " req pulses"}, n_req - b_req, dreq);
      chk({tag, " we pulses"},  n_we - b_we,   dwe);
      chk({tag, " err pulses"}, n_err - b_err, derr);
      chk({tag, " amt"},        o_amt,         exp_amt);
      chk({tag, " addr"},       o_reg_addr,    exp_addr);
      chk({tag, " wdata"},      o_reg_wdata,   exp_wdata);
      chk({tag, " err_cnt"},    o_err_cnt,     exp_cnt);
      chk({tag, " busy"},       o_busy,        1'b0);
   endtask

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{bytes:64'hA5_01_01_03_05_000000, n:5, d_req:1, d_we:0, d_err:0,
                 amt:8'h03, addr:8'h00, wdata:8'h00, cnt:8'd0};
      tbl[1] = '{bytes:64'hA5_02_02_10_7F_93_0000, n:6, d_req:0, d_we:1, d_err:0,
                 amt:8'h03, addr:8'h10, wdata:8'h7F, cnt:8'd0};
      tbl[2] = '{bytes:64'hA5_01_01_03_06_000000, n:5, d_req:0, d_we:0, d_err:1,
                 amt:8'h03, addr:8'h10, wdata:8'h7F, cnt:8'd1};
      tbl[3] = '{bytes:64'h11_22_A5_01_01_07_09_00, n:7, d_req:1, d_we:0, d_err:0,
                 amt:8'h07, addr:8'h10, wdata:8'h7F, cnt:8'd1};
      tbl[4] = '{bytes:64'hA5_01_05_0000000000, n:3, d_req:0, d_we:0, d_err:1,
                 amt:8'h07, addr:8'h10, wdata:8'h7F, cnt:8'd2};
      tbl[5] = '{bytes:64'hA5_03_00_03_00000000, n:4, d_req:0, d_we:0, d_err:1,
                 amt:8'h07, addr:8'h10, wdata:8'h7F, cnt:8'd3};
      tbl[6] = '{bytes:64'hA5_01_02_01_02_05_0000, n:6, d_req:0, d_we:0, d_err:1,
                 amt:8'h07, addr:8'h10, wdata:8'h7F, cnt:8'd4};
      tbl[7] = '{bytes:64'hA5_01_02_01_02_06_0000, n:6, d_req:0, d_we:0, d_err:1,
                 amt:8'h07, addr:8'h10, wdata:8'h7F, cnt:8'd5};
      tbl[8] = '{bytes:64'hA5_02_02_A5_00_A9_0000, n:6, d_req:0, d_we:1, d_err:0,
                 amt:8'h07, addr:8'hA5, wdata:8'h00, cnt:8'd5};
      tbl[9] = '{bytes:64'hA5_01_00_01_00000000, n:4, d_req:0, d_we:0, d_err:1,
                 amt:8'h07, addr:8'hA5, wdata:8'h00, cnt:8'd6};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset req",   o_req,       1'b0);
      chk("reset amt",   o_amt,       8'h00);
      chk("reset we",    o_reg_we,    1'b0);
      chk("reset err",   o_err,       1'b0);
      chk("reset cnt",   o_err_cnt,   8'h00);
      chk("reset busy",  o_busy,      1'b0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // table of packets
      for (int r = 0; r < 10; r++) begin
         snap();
         for (int i = 0; i < tbl[r].n; i++) send_byte(tbl[r].bytes[63-8*i -: 8], 1);
         exp_amt = tbl[r].amt; exp_addr = tbl[r].addr;
         exp_wdata = tbl[r].wdata; exp_cnt = tbl[r].cnt;
         settle($sformatf("row%0d", r), tbl[r].d_req, tbl[r].d_we, tbl[r].d_err);
      end

      // pulse timing and a sync byte landing in the EXEC cycle
      snap();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
      send_byte(8'h03, 0); send_byte(8'h05, 0);
      chk("exec req at +1", o_req, 1'b1);
      chk("exec amt at +1", o_amt, 8'h03);
      send_byte(8'hA5, 0);
      chk("exec req width", o_req, 1'b0);
      chk("exec sync busy", o_busy, 1'b1);
      send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h07, 0); send_byte(8'h09, 0);
      exp_amt = 8'h07;
      settle("exec", 2, 0, 0);

      // inter-byte timeout
      snap();
      send_byte(8'hA5, 1); send_byte(8'h01, 1);
      repeat (TMO - 1) begin @(posedge clk); #1; end
      chk("tmo err before", o_err, 1'b0);
      chk("tmo busy before", o_busy, 1'b1);
      @(posedge clk); #1;
      chk("tmo err pulse", o_err, 1'b1);
      chk("tmo busy after", o_busy, 1'b0);
      exp_cnt = sat_inc(exp_cnt);
      settle("tmo", 0, 0, 1);

      // byte arriving exactly on the expiry cycle is accepted
      snap();
      send_byte(8'hA5, 1); send_byte(8'h01, 1);
      send_byte(8'h01, TMO - 1);
      chk("edge err", o_err, 1'b0);
      chk("edge busy", o_busy, 1'b1);
      send_byte(8'h03, 1); send_byte(8'h05, 1);
      exp_amt = 8'h03;
      settle("edge", 1, 0, 0);

      // random packets against the packet-level model
      for (int k = 0; k < 200; k++) begin
         snap();
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            do r_jb = 8'($urandom_range(0, 255)); while (r_jb == 8'hA5);
            send_byte(r_jb, int'($urandom_range(0, 4)));
         end
         case ($urandom_range(0, 9))
            0, 1, 2, 3: r_opc = 8'h01;
            4, 5, 6, 7: r_opc = 8'h02;
            default:    r_opc = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 9) < 8) r_len = (r_opc == 8'h02) ? 8'd2 : 8'd1;
         else                          r_len = 8'($urandom_range(0, 7));
         r_good = r_opc + r_len;
         for (int j = 0; j < 4; j++) begin
            r_pay[j] = 8'($urandom_range(0, 255));
            if (j < int'(r_len)) r_good = r_good + r_pay[j];
         end
         r_csum = ($urandom_range(0, 4) == 0) ? (r_good ^ 8'($urandom_range(1, 255))) : r_good;

         e_req = 0; e_we = 0; e_err = 0;
         if (r_len > 8'd4 || r_csum != r_good) begin
            e_err = 1;
         end else if (r_opc == 8'h01 && r_len == 8'd1) begin
            e_req = 1; exp_amt = r_pay[0];
         end else if (r_opc == 8'h02 && r_len == 8'd2) begin
            e_we = 1; exp_addr = r_pay[0]; exp_wdata = r_pay[1];
         end else begin
            e_err = 1;
         end
         if (e_err == 1) exp_cnt = sat_inc(exp_cnt);

         send_byte(8'hA5, int'($urandom_range(0, 4)));
         send_byte(r_opc, int'($urandom_range(0, 4)));
         send_byte(r_len, int'($urandom_range(0, 4)));
         if (r_len <= 8'd4) begin
            for (int j = 0; j < int'(r_len); j++) send_byte(r_pay[j], int'($urandom_range(0, 4)));
            send_byte(r_csum, int'($urandom_range(0, 4)));
         end
         settle($sformatf("rnd%0d", k), e_req, e_we, e_err);
      end

      // reset in the middle of a packet
      send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h01, 1);
      resetn = 1'b0;
      #1;
      chk("midrst req",   o_req,       1'b0);
      chk("midrst amt",   o_amt,       8'h00);
      chk("midrst we",    o_reg_we,    1'b0);
      chk("midrst addr",  o_reg_addr,  8'h00);
      chk("midrst wdata", o_reg_wdata, 8'h00);
      chk("midrst err",   o_err,       1'b0);
      chk("midrst cnt",   o_err_cnt,   8'h00);
      chk("midrst busy",  o_busy,      1'b0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      exp_amt = 8'h00; exp_addr = 8'h00; exp_wdata = 8'h00; exp_cnt = 8'h00;
      snap();
      send_byte(8'h03, 1); send_byte(8'h05, 1);
      settle("postrst", 0, 0, 0);

      // error counter saturation
      snap();
      for (int i = 1; i <= 300; i++) begin
         send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h05, 1);
         if (i == 254) chk("sat cnt 254", o_err_cnt, 8'hFE);
         if (i == 255) chk("sat cnt 255", o_err_cnt, 8'hFF);
      end
      exp_cnt = 8'hFF;
      settle("sat", 0, 0, 300);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
